exe_thread_sequencer: RTL and testbench

Parametrised successor to the single-context entry-point/fetch front end of the execution unit. It holds NUM_THREADS independent code contexts (IP, state, return code) and time-multiplexes them onto one shared instruction memory port and one decode/execute pipeline. It sits between the instruction ROM and the decode unit, with at most one instruction in flight. Completion, branch and exit events come back from the execute stage tagged with a thread ID.

---
 rtl/exe_thread_sequencer_pkg.sv | 21 ++
 rtl/exe_thread_sequencer_if.sv | 57 +++++
 rtl/exe_thread_sequencer_rr_arbiter.sv | 45 ++++
 rtl/exe_thread_sequencer.sv | 176 +++++++++++++++++
 tb/tb_exe_thread_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/exe_thread_sequencer_pkg.sv
// Shared encodings and default widths for the thread sequencer.
// Thread states, fetch states, ROM address and instruction widths.
package exe_thread_sequencer_pkg;

   localparam int SEQ_ROM_AW  = 16;
   localparam int SEQ_INSTR_W = 64;

   typedef enum logic [1:0] {
      T_IDLE   = 2'd0,
      T_READY  = 2'd1,
      T_ISSUED = 2'd2,
      T_DONE   = 2'd3
   } thread_state_e;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_WAIT = 2'd1,
      F_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/exe_thread_sequencer_if.sv
// Bundle of trigger, imem, decode, execute and status signals.
// master: sequencer side; slave: ROM/decode/execute environment.
// EXE_SEQ_PERF_CNT_EN adds oRetiredCount (32 bits per thread).
interface exe_thread_sequencer_if #(
   parameter int NUM_THREADS = 4,
   parameter int TID_W       = $clog2(NUM_THREADS),
   parameter int ROM_AW      = 16,
   parameter int INSTR_W     = 64
);
   logic [NUM_THREADS-1:0]        iTrigger;
   logic [NUM_THREADS*ROM_AW-1:0] iInitialCodeAddress;
   logic                          oIMemRead;
   logic [ROM_AW-1:0]             oIMemAddress;
   logic [INSTR_W-1:0]            iIMemData;
   logic [INSTR_W-1:0]            oInstruction;
   logic                          oInstructionValid;
   logic [TID_W-1:0]              oThreadID;
   logic                          iDecodeReady;
   logic                          iExeDone;
   logic [TID_W-1:0]              iExeThreadID;
   logic                          iBranchTaken;
   logic [ROM_AW-1:0]             iBranchTarget;
   logic                          iThreadExit;
   logic                          iReturnCode;
   logic [NUM_THREADS-1:0]        oThreadBusy;
   logic [NUM_THREADS-1:0]        oThreadDone;
   logic [NUM_THREADS-1:0]        oReturnCode;
`ifdef EXE_SEQ_PERF_CNT_EN
   logic [NUM_THREADS*32-1:0]     oRetiredCount;
`endif

   modport master (
      input  iTrigger, iInitialCodeAddress, iIMemData,
      input  iDecodeReady, iExeDone, iExeThreadID,
      input  iBranchTaken, iBranchTarget,
      input  iThreadExit, iReturnCode,
`ifdef EXE_SEQ_PERF_CNT_EN
      output oRetiredCount,
`endif
      output oIMemRead, oIMemAddress, oInstruction,
      output oInstructionValid, oThreadID,
      output oThreadBusy, oThreadDone, oReturnCode
   );

   modport slave (
      output iTrigger, iInitialCodeAddress, iIMemData,
      output iDecodeReady, iExeDone, iExeThreadID,
      output iBranchTaken, iBranchTarget,
      output iThreadExit, iReturnCode,
`ifdef EXE_SEQ_PERF_CNT_EN
      input  oRetiredCount,
`endif
      input  oIMemRead, oIMemAddress, oInstruction,
      input  oInstructionValid, oThreadID,
      input  oThreadBusy, oThreadDone, oReturnCode
   );
endinterface

// File: rtl/exe_thread_sequencer_rr_arbiter.sv
// Round-robin arbiter; search starts at the pointer, which moves
// to grant+1 on adv. Ports: req, adv in; gnt_oh, gnt_idx, gnt_any out.
module rr_arbiter
   import exe_thread_sequencer_pkg::*;
#(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] gnt_oh,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_any
);
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] idx;

   // Scan from farthest offset down so the nearest request wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = ptr_q + W'(i);
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
      if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv && gnt_any) ptr_d = gnt_idx + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
endmodule

// File: rtl/exe_thread_sequencer.sv
// Multi-context fetch front end: per-thread IP/state, RR fetch, one in flight.
// Ports: Clock, Reset, bus (master). EXE_SEQ_PERF_CNT_EN adds retire counters.
module exe_thread_sequencer
   import exe_thread_sequencer_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int TID_W       = $clog2(NUM_THREADS),
   parameter int ROM_AW      = SEQ_ROM_AW,
   parameter int INSTR_W     = SEQ_INSTR_W
) (
   input  logic Clock,
   input  logic Reset,
   exe_thread_sequencer_if.master bus
);
   thread_state_e          st_q [NUM_THREADS];
   thread_state_e          st_d [NUM_THREADS];
   logic [ROM_AW-1:0]      ip_q [NUM_THREADS];
   logic [ROM_AW-1:0]      ip_d [NUM_THREADS];
   logic [NUM_THREADS-1:0] done_q, done_d, rc_q, rc_d;
   logic [NUM_THREADS-1:0] req, hit, trg_ok, busy, gnt_oh;
   logic [TID_W-1:0]       gnt_idx, gid_q, gid_d, tid_q, tid_d;
   logic                   gnt_any, blocked, fire;
   fetch_state_e           fst_q, fst_d;
   logic                   rd_q, rd_d;
   logic [ROM_AW-1:0]      addr_q, addr_d;
   logic [INSTR_W-1:0]     instr_q, instr_d;

   // A thread retiring this cycle no longer blocks a new grant.
   always_comb begin
      req     = '0;
      hit     = '0;
      trg_ok  = '0;
      busy    = '0;
      blocked = 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         req[i]    = st_q[i] == T_READY;
         busy[i]   = st_q[i] == T_READY || st_q[i] == T_ISSUED;
         hit[i]    = bus.iExeDone && st_q[i] == T_ISSUED &&
                     bus.iExeThreadID == TID_W'(i);
         trg_ok[i] = bus.iTrigger[i] &&
                     (st_q[i] == T_IDLE || st_q[i] == T_DONE);
         if (st_q[i] == T_ISSUED && !hit[i]) blocked = 1'b1;
      end
      fire = fst_q == F_IDLE && !blocked && gnt_any;
   end

   rr_arbiter #(.N(NUM_THREADS), .W(TID_W)) u_arb (
      .clk     (Clock),
      .rst     (Reset),
      .req     (req),
      .adv     (fire),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         st_d[i]   = st_q[i];
         ip_d[i]   = ip_q[i];
         done_d[i] = done_q[i];
         rc_d[i]   = rc_q[i];
         unique case (st_q[i])
            T_IDLE, T_DONE: if (trg_ok[i]) begin
               st_d[i]   = T_READY;
               ip_d[i]   = bus.iInitialCodeAddress[i*ROM_AW +: ROM_AW];
               done_d[i] = 1'b0;
               rc_d[i]   = 1'b0;
            end
            T_READY: if (fire && gnt_oh[i]) st_d[i] = T_ISSUED;
            T_ISSUED: if (hit[i]) begin
               if (bus.iThreadExit) begin
                  st_d[i]   = T_DONE;
                  done_d[i] = 1'b1;
                  rc_d[i]   = bus.iReturnCode;
               end else begin
                  st_d[i] = T_READY;
                  ip_d[i] = bus.iBranchTaken ? bus.iBranchTarget
                                             : ip_q[i] + ROM_AW'(1);
               end
            end
            default: st_d[i] = T_IDLE;
         endcase
      end
   end

   always_comb begin
      fst_d   = fst_q;
      rd_d    = 1'b0;
      addr_d  = addr_q;
      instr_d = instr_q;
      gid_d   = gid_q;
      tid_d   = tid_q;
      unique case (fst_q)
         F_IDLE: if (fire) begin
            rd_d   = 1'b1;
            addr_d = ip_q[gnt_idx];
            gid_d  = gnt_idx;
            fst_d  = F_WAIT;
         end
         F_WAIT: begin
            instr_d = bus.iIMemData;
            tid_d   = gid_q;
            fst_d   = F_HOLD;
         end
         F_HOLD: if (bus.iDecodeReady) fst_d = F_IDLE;
         default: fst_d = F_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            st_q[i] <= T_IDLE;
            ip_q[i] <= '0;
         end
         done_q  <= '0;
         rc_q    <= '0;
         fst_q   <= F_IDLE;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         instr_q <= '0;
         gid_q   <= '0;
         tid_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            st_q[i] <= st_d[i];
            ip_q[i] <= ip_d[i];
         end
         done_q  <= done_d;
         rc_q    <= rc_d;
         fst_q   <= fst_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         gid_q   <= gid_d;
         tid_q   <= tid_d;
      end
   end

   assign bus.oIMemRead         = rd_q;
   assign bus.oIMemAddress      = addr_q;
   assign bus.oInstruction      = instr_q;
   assign bus.oInstructionValid = fst_q == F_HOLD;
   assign bus.oThreadID         = tid_q;
   assign bus.oThreadBusy       = busy;
   assign bus.oThreadDone       = done_q;
   assign bus.oReturnCode       = rc_q;

`ifdef EXE_SEQ_PERF_CNT_EN
   logic [31:0] cnt_q [NUM_THREADS];
   logic [31:0] cnt_d [NUM_THREADS];

   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (trg_ok[i])
            cnt_d[i] = '0;
         else if (hit[i] && cnt_q[i] != 32'hFFFF_FFFF)
            cnt_d[i] = cnt_q[i] + 32'd1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_THREADS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_THREADS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   for (genvar g = 0; g < NUM_THREADS; g++) begin : g_cnt
      assign bus.oRetiredCount[g*32 +: 32] = cnt_q[g];
   end
`endif
endmodule

// File: tb/tb_exe_thread_sequencer.sv
// Directed bench for exe_thread_sequencer (4 threads, 16-bit IP).
// ROM model returns {16'hABCD, 32'h0, address}.
module tb_exe_thread_sequencer;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   exe_thread_sequencer_if bus ();

   exe_thread_sequencer dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   assign bus.iIMemData = {16'hABCD, 32'h0, bus.oIMemAddress};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic trig(input logic [3:0] m);
      bus.iTrigger = m;
      tick();
      bus.iTrigger = '0;
   endtask

   task automatic accept();
      bus.iDecodeReady = 1'b1;
      tick();
      bus.iDecodeReady = 1'b0;
   endtask

   task automatic retire(input logic [1:0] id, input logic br,
                         input logic [15:0] tgt, input logic ex,
                         input logic rc);
      bus.iExeDone      = 1'b1;
      bus.iExeThreadID  = id;
      bus.iBranchTaken  = br;
      bus.iBranchTarget = tgt;
      bus.iThreadExit   = ex;
      bus.iReturnCode   = rc;
      tick();
      bus.iExeDone      = 1'b0;
      bus.iBranchTaken  = 1'b0;
      bus.iThreadExit   = 1'b0;
      bus.iReturnCode   = 1'b0;
   endtask

   task automatic wait_fetch(input string tag, input logic [15:0] a);
      for (int n = 0; n < 20; n++) begin
         if (bus.oIMemRead) break;
         tick();
      end
      chk({tag, "_rd"}, 64'(bus.oIMemRead), 64'd1);
      chk(tag, 64'(bus.oIMemAddress), 64'(a));
   endtask

   task automatic serve(input string tag, input logic [1:0] id,
                        input logic br, input logic [15:0] tgt,
                        input logic ex, input logic rc);
      tick();
      chk({tag, "_v"}, 64'(bus.oInstructionValid), 64'd1);
      chk({tag, "_id"}, 64'(bus.oThreadID), 64'(id));
      accept();
      retire(id, br, tgt, ex, rc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [15:0] ord_a [5];
   logic [1:0]  ord_t [5];

   initial begin
      rst                     = 1'b1;
      bus.iTrigger            = '0;
      bus.iInitialCodeAddress = '0;
      bus.iDecodeReady        = 1'b0;
      bus.iExeDone            = 1'b0;
      bus.iExeThreadID        = '0;
      bus.iBranchTaken        = 1'b0;
      bus.iBranchTarget       = '0;
      bus.iThreadExit         = 1'b0;
      bus.iReturnCode         = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_rd", 64'(bus.oIMemRead), 64'd0);
      chk("rst_v", 64'(bus.oInstructionValid), 64'd0);
      chk("rst_busy", 64'(bus.oThreadBusy), 64'd0);
      chk("rst_done", 64'(bus.oThreadDone), 64'd0);

      // single thread latency
      bus.iInitialCodeAddress = {16'h0, 16'h0, 16'h0, 16'h0040};
      trig(4'b0001);
      chk("t1_busy", 64'(bus.oThreadBusy), 64'h1);
      chk("t1_rd0", 64'(bus.oIMemRead), 64'd0);
      tick();
      chk("t1_rd", 64'(bus.oIMemRead), 64'd1);
      chk("t1_addr", 64'(bus.oIMemAddress), 64'h40);
      tick();
      chk("t1_v", 64'(bus.oInstructionValid), 64'd1);
      chk("t1_id", 64'(bus.oThreadID), 64'd0);
      chk("t1_ins", bus.oInstruction, 64'hABCD_0000_0000_0040);
      chk("t1_rdoff", 64'(bus.oIMemRead), 64'd0);
      accept();
      chk("t1_vdrop", 64'(bus.oInstructionValid), 64'd0);
      retire(2'd0, 1'b0, 16'h0, 1'b0, 1'b0);
`ifdef EXE_SEQ_PERF_CNT_EN
      chk("t1_cnt", 64'(bus.oRetiredCount[31:0]), 64'd1);
`endif
      wait_fetch("t1_seq", 16'h0041);
      serve("t1_b", 2'd0, 1'b1, 16'h0100, 1'b0, 1'b0);
      wait_fetch("t1_br", 16'h0100);
      do_reset();

      // round robin over four threads
      bus.iInitialCodeAddress = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
      ord_a = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0011};
      ord_t = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      trig(4'b1111);
      chk("rr_busy", 64'(bus.oThreadBusy), 64'hF);
      for (int k = 0; k < 4; k++) begin
         wait_fetch($sformatf("rr_f%0d", k), ord_a[k]);
         serve($sformatf("rr_s%0d", k), ord_t[k], 1'b0, 16'h0,
               1'b0, 1'b0);
      end
      wait_fetch("rr_f4", ord_a[4]);

      // decode stall
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("st_rd", 64'(bus.oIMemRead), 64'd0);
         chk("st_v", 64'(bus.oInstructionValid), 64'd1);
      end
      chk("st_ins", bus.oInstruction, 64'hABCD_0000_0000_0011);
      chk("st_id", 64'(bus.oThreadID), 64'd0);
      accept();
      chk("st_rel", 64'(bus.oInstructionValid), 64'd0);
      retire(2'd0, 1'b0, 16'h0, 1'b0, 1'b0);

      // trigger on an issued thread is ignored
      wait_fetch("ig_f1", 16'h0021);
      bus.iInitialCodeAddress = {16'h0040, 16'h0030, 16'h0500, 16'h0010};
      trig(4'b0010);
      chk("ig_busy", 64'(bus.oThreadBusy), 64'hF);
      serve("ig_s1", 2'd1, 1'b0, 16'h0, 1'b0, 1'b0);

      // exit with return code
      wait_fetch("ex_f2", 16'h0031);
      serve("ex_s2", 2'd2, 1'b0, 16'h0, 1'b1, 1'b1);
      chk("ex_done", 64'(bus.oThreadDone), 64'h4);
      chk("ex_rc", 64'(bus.oReturnCode), 64'h4);
      chk("ex_busy", 64'(bus.oThreadBusy[2]), 64'd0);
      wait_fetch("ex_f3", 16'h0041);
      serve("ex_s3", 2'd3, 1'b0, 16'h0, 1'b1, 1'b0);
      wait_fetch("ex_f0", 16'h0012);
      serve("ex_s0", 2'd0, 1'b0, 16'h0, 1'b1, 1'b0);
      wait_fetch("ig_ip1", 16'h0022);
      serve("ex_s1", 2'd1, 1'b0, 16'h0, 1'b1, 1'b0);
      chk("all_done", 64'(bus.oThreadDone), 64'hF);
      retire(2'd3, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("stray_busy", 64'(bus.oThreadBusy), 64'h0);
      chk("stray_done", 64'(bus.oThreadDone), 64'hF);

      // retrigger and IP wrap
      bus.iInitialCodeAddress = {16'h0, 16'hFFFF, 16'h0, 16'h0};
      trig(4'b0100);
      chk("rt_done", 64'(bus.oThreadDone), 64'hB);
      chk("rt_rc", 64'(bus.oReturnCode), 64'h0);
      chk("rt_busy", 64'(bus.oThreadBusy), 64'h4);
      wait_fetch("wr_f", 16'hFFFF);
      serve("wr_s", 2'd2, 1'b0, 16'h0, 1'b0, 1'b0);
      wait_fetch("wr_0", 16'h0000);

      // asynchronous reset in F_WAIT
      #2;
      rst = 1'b1;
      #1;
      chk("ar_rd", 64'(bus.oIMemRead), 64'd0);
      chk("ar_v", 64'(bus.oInstructionValid), 64'd0);
      chk("ar_busy", 64'(bus.oThreadBusy), 64'h0);
      chk("ar_done", 64'(bus.oThreadDone), 64'h0);
      chk("ar_ins", bus.oInstruction, 64'h0);
      tick();
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
